aes: RTL and testbench

- Byte-serial AES-128 encryption core with an iterative datapath that computes one round per clock.
- A host streams one 34-byte frame over an 8-bit bus: 16 plaintext bytes, a key-size byte, 16 key bytes, then a command byte.
- The core encrypts per FIPS-197 and presents the 128-bit ciphertext on a registered output.
- It is the standalone crypto engine behind the byte-wide host interface.

---
 rtl/aes.sv | 148 ++++++++++++++
 tb/tb_aes.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/aes.sv
// Byte-serial AES-128 encryption core: a 34-byte frame is loaded over an 8-bit bus,
// then one round per clock with on-the-fly key expansion; ciphertext lands in 'out'.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset of entry a is (255-a)*8.
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [7:0]   Indata,
  output logic [127:0] out
);
  typedef enum logic {LOAD, RUN} state_t;

  state_t       fsm;
  logic [5:0]   cnt;
  logic         kerr;
  logic [127:0] pt, key, st, rk;
  logic [3:0]   rnd;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [7:0]   ks [4];
  logic [31:0]  rot, temp, w0, w1, w2, w3;
  logic [127:0] nk, nxt;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_sb
      aes_sbox u_sb (.a(st[8*(15-g) +: 8]), .y(sb[g]));
    end
    for (g = 0; g < 4; g++) begin : g_ks
      aes_sbox u_ks (.a(rot[8*(3-g) +: 8]), .y(ks[g]));
    end
  endgenerate

  assign rot = {rk[23:0], rk[31:24]};

  always_comb begin
    temp = {ks[0], ks[1], ks[2], ks[3]} ^ {rcon(rnd), 24'h000000};
    w0   = rk[127:96] ^ temp;
    w1   = rk[95:64]  ^ w0;
    w2   = rk[63:32]  ^ w1;
    w3   = rk[31:0]   ^ w2;
    nk   = {w0, w1, w2, w3};
  end

  // Byte j = 4*col + row; ShiftRows pulls row r from column (col + r) mod 4.
  always_comb begin
    sr  = '{default: '0};
    mc  = '{default: '0};
    nxt = '0;
    for (int unsigned j = 0; j < 16; j++)
      sr[j] = sb[4*(((j/4) + (j%4)) % 4) + (j%4)];
    for (int unsigned c = 0; c < 4; c++) begin
      mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
    for (int unsigned j = 0; j < 16; j++)
      nxt[8*(15-j) +: 8] = ((rnd == 4'd10) ? sr[j] : mc[j]) ^ nk[8*(15-j) +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out  <= '0;
      cnt  <= '0;
      fsm  <= LOAD;
      kerr <= 1'b0;
      pt   <= '0;
      key  <= '0;
      st   <= '0;
      rk   <= '0;
      rnd  <= '0;
    end else begin
      case (fsm)
        LOAD: if (we) begin
          cnt <= cnt + 6'd1;
          // Shifting bytes in from the bottom yields big-endian packing after 16 writes.
          if (cnt < 6'd16)
            pt <= {pt[119:0], Indata};
          else if (cnt == 6'd16)
            kerr <= (Indata != 8'h10);
          else if (cnt < 6'd33)
            key <= {key[119:0], Indata};
          else begin
            cnt  <= '0;
            kerr <= 1'b0;
            if (Indata == 8'h01 && !kerr) begin
              st  <= pt ^ key;
              rk  <= key;
              rnd <= 4'd1;
              fsm <= RUN;
            end
          end
        end
        RUN: begin
          st  <= nxt;
          rk  <= nk;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd10) begin
            out <= nxt;
            fsm <= LOAD;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes.sv
// Directed bench for the byte-serial AES-128 core using FIPS-197 vectors,
// covering latency, we gaps, unsupported frames, mid-run reset and busy input.

module tb_aes;
  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [7:0]   Indata;
  logic [127:0] out;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  aes dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .Indata (Indata),
    .out    (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    we     = 1'b1;
    Indata = b;
    @(posedge clk);
    #1;
    we     = 1'b0;
  endtask

  // Leaves the caller 1 time unit after the command edge.
  task automatic frame(input logic [127:0] p, input logic [7:0] sz,
                       input logic [127:0] k, input logic [7:0] cmd, input bit gaps);
    logic [127:0] t;
    t = p;
    for (int i = 0; i < 16; i++) begin
      send(t[127:120]);
      t = t << 8;
      if (gaps && i == 5) idle(3);
    end
    send(sz);
    if (gaps) idle(3);
    t = k;
    for (int i = 0; i < 16; i++) begin
      send(t[127:120]);
      t = t << 8;
      if (gaps && i == 13) idle(3);
    end
    send(cmd);
  endtask

  // Result must appear exactly on the 10th edge after the command edge.
  task automatic await_ct(input string tag, input logic [127:0] prev,
                          input logic [127:0] exp, input bit busy);
    for (int i = 1; i <= 10; i++) begin
      if (busy) begin
        we     = 1'($urandom_range(0, 1));
        Indata = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (i < 10) chk({tag, "_early"}, out, prev);
      else        chk(tag, out, exp);
    end
    we = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    Indata = 8'h00;
    idle(2);
    chk("reset_out", out, '0);
    reset = 1'b0;

    frame(C1_PT, 8'h10, C1_KEY, 8'h01, 1'b0);
    await_ct("c1", '0, C1_CT, 1'b0);

    frame(B_PT, 8'h10, B_KEY, 8'h01, 1'b0);
    await_ct("appb_b2b", C1_CT, B_CT, 1'b0);

    frame(C1_PT, 8'h10, C1_KEY, 8'h02, 1'b0);
    idle(12);
    chk("cmd02_hold", out, B_CT);

    frame(C1_PT, 8'h20, C1_KEY, 8'h01, 1'b0);
    idle(12);
    chk("size20_hold", out, B_CT);

    frame(C1_PT, 8'h10, C1_KEY, 8'h01, 1'b1);
    await_ct("c1_gaps", B_CT, C1_CT, 1'b0);

    frame(B_PT, 8'h10, B_KEY, 8'h01, 1'b0);
    await_ct("appb_after_err", C1_CT, B_CT, 1'b0);

    frame(C1_PT, 8'h10, C1_KEY, 8'h01, 1'b0);
    idle(3);
    chk("midrun_hold", out, B_CT);
    reset = 1'b1;
    idle(1);
    chk("midrun_reset", out, '0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      chk("no_late_update", out, '0);
    end

    frame(C1_PT, 8'h10, C1_KEY, 8'h01, 1'b0);
    await_ct("c1_after_reset", '0, C1_CT, 1'b0);

    frame(B_PT, 8'h10, B_KEY, 8'h01, 1'b0);
    await_ct("appb_busy", C1_CT, B_CT, 1'b1);

    frame(C1_PT, 8'h10, C1_KEY, 8'h01, 1'b0);
    await_ct("c1_after_busy", B_CT, C1_CT, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
